// File: rtl/mul_div_unit_pkg.sv
// Shared types and op encodings for the EX-stage iterative multiply/divide unit.
package mul_div_unit_pkg;

    // FSM state of the multiply/divide unit; the hazard unit stalls while not IDLE.
    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_CALC = 2'd1,
        MD_ST_FIX  = 2'd2,
        MD_ST_DONE = 2'd3
    } md_state_e;

    // Operation codes, numbered alongside the ALU op codes.
    localparam logic [2:0] MD_MUL   = 3'd0;
    localparam logic [2:0] MD_SMULH = 3'd1;
    localparam logic [2:0] MD_UMULH = 3'd2;
    localparam logic [2:0] MD_SDIV  = 3'd3;
    localparam logic [2:0] MD_UDIV  = 3'd4;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_SDIV) || (op == MD_UDIV);
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_SMULH) || (op == MD_SDIV);
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, sharing a single WORD+1 bit adder/subtractor.
// Signed ops run on magnitudes and the sign is restored in the FIX cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WORD = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] result,
    output logic            div_by_zero
);

    localparam int PW = 2 * WORD;
    localparam int CW = $clog2(WORD);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD - 1);

    function automatic logic [WORD-1:0] neg_w(input logic [WORD-1:0] v);
        return ~v + WORD'(1);
    endfunction

    function automatic logic [PW-1:0] neg_p(input logic [PW-1:0] v);
        return ~v + PW'(1);
    endfunction

    // Magnitude of a two's-complement value when en is set; the minimum value
    // maps to 2^(WORD-1), which is still exact as an unsigned WORD-bit number.
    function automatic logic [WORD-1:0] abs_w(input logic [WORD-1:0] v, input logic en);
        return (en && v[WORD-1]) ? neg_w(v) : v;
    endfunction

    md_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [WORD-1:0] opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [WORD-1:0] hi_q, hi_d;       // product high word / partial remainder
    logic [WORD-1:0] lo_q, lo_d;       // multiplier->product low word / dividend->quotient
    logic [WORD-1:0] result_q, result_d;
    logic            dbz_q, dbz_d;

    logic            is_div_q;
    logic [WORD:0]   div_shift;
    logic [WORD:0]   add_a, add_b, add_sum;
    logic            add_sub;
    logic [PW-1:0]   product;
    logic [WORD-1:0] quotient;
    logic [WORD-1:0] fix_result;

    assign is_div_q = md_is_div(op_q);

    // Shared adder: adds the multiplicand for multiply, subtracts the divisor
    // from the shifted partial remainder for divide.
    always_comb begin
        div_shift = {hi_q, lo_q[WORD-1]};
        if (is_div_q) begin
            add_a   = div_shift;
            add_b   = {1'b0, opnd_q};
            add_sub = 1'b1;
        end else begin
            add_a   = {1'b0, hi_q};
            add_b   = lo_q[0] ? {1'b0, opnd_q} : '0;
            add_sub = 1'b0;
        end
        add_sum = add_a + (add_sub ? ~add_b : add_b) + {{WORD{1'b0}}, add_sub};
    end

    // Sign fix-up and output selection used in the FIX cycle.
    always_comb begin
        product = {hi_q, lo_q};
        if (neg_q) product = neg_p(product);
        quotient = neg_q ? neg_w(lo_q) : lo_q;
        case (op_q)
            MD_SMULH, MD_UMULH: fix_result = product[PW-1:WORD];
            MD_SDIV, MD_UDIV:   fix_result = quotient;
            default:            fix_result = product[WORD-1:0];
        endcase
    end

    // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            MD_ST_IDLE: begin
                if (start && !flush) begin
                    op_d  = op;
                    neg_d = md_is_signed(op) && (a[WORD-1] ^ b[WORD-1]);
                    if (md_is_div(op) && (b == '0)) begin
                        result_d = '0;
                        dbz_d    = 1'b1;
                        state_d  = MD_ST_DONE;
                    end else begin
                        cnt_d   = '0;
                        hi_d    = '0;
                        state_d = MD_ST_CALC;
                        if (md_is_div(op)) begin
                            opnd_d = abs_w(b, md_is_signed(op));
                            lo_d   = abs_w(a, md_is_signed(op));
                        end else begin
                            opnd_d = abs_w(a, md_is_signed(op));
                            lo_d   = abs_w(b, md_is_signed(op));
                        end
                    end
                end
            end
            MD_ST_CALC: begin
                if (is_div_q) begin
                    // Subtraction result is negative exactly when bit WORD is set.
                    hi_d = add_sum[WORD] ? div_shift[WORD-1:0] : add_sum[WORD-1:0];
                    lo_d = {lo_q[WORD-2:0], ~add_sum[WORD]};
                end else begin
                    hi_d = add_sum[WORD:1];
                    lo_d = {add_sum[0], lo_q[WORD-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = MD_ST_FIX;
            end
            MD_ST_FIX: begin
                result_d = fix_result;
                dbz_d    = 1'b0;
                state_d  = MD_ST_DONE;
            end
            MD_ST_DONE: begin
                state_d = MD_ST_IDLE;
            end
            default: state_d = MD_ST_IDLE;
        endcase

        // Abort from hazard/branch logic beats everything; published outputs hold.
        if (flush) begin
            state_d  = MD_ST_IDLE;
            result_d = result_q;
            dbz_d    = dbz_q;
        end
    end

    // State and datapath registers.
    // NOTE: non-blocking assignments so every register samples the pre-edge
    // values; the datapath registers are reset too, since they are few and
    // reset keeps result/div_by_zero defined before the first operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_ST_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != MD_ST_IDLE);
    assign done        = (state_q == MD_ST_DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a latency/arithmetic reference model
// compared every cycle, plus directed vectors with hand-computed results.
`timescale 1ns/1ps
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int WORD = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [2:0]      op;
    logic [WORD-1:0] a;
    logic [WORD-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [WORD-1:0] result;
    logic            div_by_zero;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    mul_div_unit #(.WORD(WORD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    task automatic check_word(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, required %b", name, act, exp);
    endtask

    // Reference arithmetic on double-width integers.
    function automatic logic [WORD-1:0] ref_result(input logic [2:0] o, input logic [WORD-1:0] x, input logic [WORD-1:0] y);
        logic signed [2*WORD-1:0] sx, sy, sp;
        logic [2*WORD-1:0]        ux, uy, up;
        sx = {{WORD{x[WORD-1]}}, x};
        sy = {{WORD{y[WORD-1]}}, y};
        ux = {{WORD{1'b0}}, x};
        uy = {{WORD{1'b0}}, y};
        up = ux * uy;
        sp = sx * sy;
        case (o)
            MD_SMULH: return sp[2*WORD-1:WORD];
            MD_UMULH: return up[2*WORD-1:WORD];
            MD_SDIV: begin
                if (y == '0) return '0;
                sp = sx / sy;
                return sp[WORD-1:0];
            end
            MD_UDIV: begin
                if (y == '0) return '0;
                up = ux / uy;
                return up[WORD-1:0];
            end
            default: return up[WORD-1:0];
        endcase
    endfunction

    // Reference model: busy/done timing by edge counting, results from ref_result.
    logic            m_busy, m_done, m_dbz, m_pend_dbz;
    logic [WORD-1:0] m_res, m_pend_res;
    int              m_left;

    initial begin
        m_busy = 0; m_done = 0; m_dbz = 0; m_res = '0;
        m_pend_dbz = 0; m_pend_res = '0; m_left = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_done = 0; m_dbz = 0; m_res = '0; m_left = 0;
            end else if (flush) begin
                m_busy = 0; m_done = 0;
            end else if (m_done) begin
                m_busy = 0; m_done = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy     = 1;
                    m_pend_dbz = ((op == MD_SDIV) || (op == MD_UDIV)) && (b == '0);
                    m_pend_res = ref_result(op, a, b);
                    m_left     = m_pend_dbz ? 0 : WORD + 1;
                    if (m_left == 0) begin
                        m_done = 1; m_res = m_pend_res; m_dbz = m_pend_dbz;
                    end
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_res = m_pend_res; m_dbz = m_pend_dbz;
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && cmp_en) begin
                check_bit("cyc_busy", busy, m_busy);
                check_bit("cyc_done", done, m_done);
                check_word("cyc_result", result, m_res);
                check_bit("cyc_dbz", div_by_zero, m_dbz);
            end
        end
    end

    // One operation from IDLE; latency counts edges including the accepting edge.
    task automatic run_op(input string name, input logic [2:0] o, input logic [WORD-1:0] x,
                          input logic [WORD-1:0] y, input logic [WORD-1:0] exp_r,
                          input logic exp_z, input int exp_lat);
        int lat = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_bit({name, "_done"}, done, 1'b1);
        check_word({name, "_latency"}, WORD'(lat), WORD'(exp_lat));
        check_word({name, "_result"}, result, exp_r);
        check_bit({name, "_dbz"}, div_by_zero, exp_z);
    endtask

    initial begin
        int n_done;
        int lat_seen;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = MD_MUL; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_word("reset_result", result, '0);
        check_bit("reset_dbz", div_by_zero, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        run_op("mul_max",     MD_MUL,   64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66);
        run_op("smulh_m1x3",  MD_SMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66);
        run_op("umulh_m1x3",  MD_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h0000_0000_0000_0002, 1'b0, 66);
        run_op("sdiv_m7_2",   MD_SDIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 66);
        run_op("udiv_big_3",  MD_UDIV,  64'hFFFF_FFFF_FFFF_FFFD, 64'd3, 64'h5555_5555_5555_5554, 1'b0, 66);
        run_op("udiv_by0",    MD_UDIV,  64'd5, 64'd0, 64'd0, 1'b1, 1);
        run_op("sdiv_min_m1", MD_SDIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1'b0, 66);
        run_op("sdiv_7_m2",   MD_SDIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 66);
        run_op("mul_m3x5",    MD_MUL,   64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 66);
        run_op("smulh_minsq", MD_SMULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 1'b0, 66);
        run_op("umulh_maxsq", MD_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 66);
        run_op("sdiv_by0",    MD_SDIV,  64'd9, 64'd0, 64'd0, 1'b1, 1);
        run_op("udiv_max_1",  MD_UDIV,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66);

        // start pulses while busy are ignored; exactly one done with the original result
        @(negedge clk);
        start = 1'b1; op = MD_MUL; a = 64'h1_2345_6789; b = 64'h1000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_done = 0; lat_seen = 0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 10 || c == 40) begin
                start = 1'b1; op = MD_UDIV; a = 64'd5; b = 64'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (c == 10 || c == 40) check_bit("ign_busy", busy, 1'b1);
            if (done) begin
                n_done++;
                lat_seen = c + 1;
                check_word("ign_result", result, 64'h0000_1234_5678_9000);
                check_bit("ign_dbz", div_by_zero, 1'b0);
            end
        end
        start = 1'b0;
        check_word("ign_done_count", WORD'(n_done), WORD'(1));
        check_word("ign_latency", WORD'(lat_seen), WORD'(66));

        // flush mid-operation: idle next cycle, no done, outputs unchanged
        @(negedge clk);
        start = 1'b1; op = MD_SDIV; a = 64'd100; b = 64'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) begin
            @(posedge clk);
            @(negedge clk);
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check_bit("flush_busy", busy, 1'b0);
        check_bit("flush_done", done, 1'b0);
        check_word("flush_result", result, 64'h0000_1234_5678_9000);
        check_bit("flush_dbz", div_by_zero, 1'b0);
        n_done = 0;
        repeat (80) begin
            @(posedge clk);
            @(negedge clk);
            if (done) n_done++;
        end
        check_word("flush_no_done", WORD'(n_done), WORD'(0));

        // flush together with start in IDLE drops the request
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = MD_MUL; a = 64'd3; b = 64'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check_bit("flush_start_busy", busy, 1'b0);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = MD_UDIV; a = 64'd1000; b = 64'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_bit("pre_rst_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_bit("async_rst_busy", busy, 1'b0);
        check_bit("async_rst_done", done, 1'b0);
        check_word("async_rst_result", result, '0);
        check_bit("async_rst_dbz", div_by_zero, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_mul", MD_MUL, 64'd3, 64'd4, 64'd12, 1'b0, 66);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
